// File: rtl/calc_pkg.sv
// Shared command/status codes and issuer state encoding for the calculator keypad path.
package calc_pkg;
    localparam logic [3:0] CMD_ADD         = 4'b1010;
    localparam logic [3:0] CMD_SUB         = 4'b1011;
    localparam logic [3:0] CMD_MUL         = 4'b1100;
    localparam logic [3:0] CMD_EQ          = 4'b1110;
    localparam logic [3:0] CMD_BS          = 4'b1111;
    localparam logic [3:0] CMD_NOP_DEFAULT = 4'b1101;

    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_ERROR     = 2'd3
    } issuer_state_e;
endpackage

// File: rtl/calc_cmd_issuer_if.sv
// Keypad/calculator-facing signal bundle of calc_cmd_issuer.
// Display capture signals exist only when CALC_DISP_CAPTURE_EN is defined.
interface calc_cmd_issuer_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          key_valid;
    logic [3:0]    key_code;
    logic          key_ready;
    logic [1:0]    status;
    logic [3:0]    cmd;
    logic [LW-1:0] fifo_level;
    logic          issuing;
    logic          err;
    logic          timeout;
`ifdef CALC_DISP_CAPTURE_EN
    logic [3:0]    data;
    logic [3:0]    pos;
    logic [31:0]   disp_digits;
    logic          disp_valid;

    modport master (
        input  key_valid, key_code, status, data, pos,
        output key_ready, cmd, fifo_level, issuing, err, timeout, disp_digits, disp_valid
    );
    modport slave (
        output key_valid, key_code, status, data, pos,
        input  key_ready, cmd, fifo_level, issuing, err, timeout, disp_digits, disp_valid
    );
`else
    modport master (
        input  key_valid, key_code, status,
        output key_ready, cmd, fifo_level, issuing, err, timeout
    );
    modport slave (
        output key_valid, key_code, status,
        input  key_ready, cmd, fifo_level, issuing, err, timeout
    );
`endif
endinterface

// File: rtl/calc_key_fifo.sv
// Small key-code FIFO with occupancy output; flush empties it in one cycle.
module calc_key_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    output logic [W-1:0]           o_head,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_level;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd];
    assign o_level   = r_level;

    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/calc_cmd_issuer.sv
// Keypad-side command issuer: queues key codes and hands them to the calculator over a
// ready/busy status handshake. Optional display rebuild enabled by CALC_DISP_CAPTURE_EN.
module calc_cmd_issuer
    import calc_pkg::*;
#(
    parameter int         DEPTH   = 4,
    parameter int         TIMEOUT = 16,
    parameter logic [3:0] NOP_CMD = CMD_NOP_DEFAULT
) (
    input logic               clock,
    input logic               reset,
    calc_cmd_issuer_if.master bus
);
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    issuer_state_e    r_state, w_state_nxt;
    logic [3:0]       r_cmd, w_cmd_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_err, w_err_nxt;
    logic             r_timeout, w_timeout_nxt;

    logic [3:0]       w_head;
    logic [LW-1:0]    w_level;
    logic             w_full;
    logic             w_empty;
    logic             w_launch;
    logic             w_push;
    logic             w_flush;
    logic             w_key_ready;

    calc_key_fifo #(.DEPTH(DEPTH), .W(4)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (bus.key_code),
        .i_pop   (w_launch),
        .o_head  (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_launch = (r_state == S_IDLE) && !r_err && !w_empty && (bus.status == ST_READY);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cmd     <= NOP_CMD;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cmd     <= w_cmd_nxt;
            r_cnt     <= w_cnt_nxt;
            r_err     <= w_err_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cmd_nxt     = r_cmd;
        w_cnt_nxt     = r_cnt;
        w_err_nxt     = r_err;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_nxt = NOP_CMD;
                if (w_launch) begin
                    w_cmd_nxt   = w_head;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.status == ST_BUSY) begin
                    w_cmd_nxt   = NOP_CMD;
                    w_state_nxt = S_WAIT_DONE;
                end else if (bus.status == ST_READY) begin
                    // Calc never acknowledged: the command is abandoned, not retried.
                    if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        w_timeout_nxt = 1'b1;
                        w_cmd_nxt     = NOP_CMD;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            S_WAIT_DONE: begin
                w_cmd_nxt = NOP_CMD;
                if (bus.status == ST_READY) w_state_nxt = S_IDLE;
            end
            default: begin
                w_cmd_nxt = NOP_CMD;
            end
        endcase
        if (bus.status == ST_ERR) begin
            w_err_nxt   = 1'b1;
            w_cmd_nxt   = NOP_CMD;
            w_state_nxt = S_ERROR;
        end
    end

    always_comb begin
        w_key_ready    = !w_full && !r_err && !(bus.key_valid && (bus.key_code == NOP_CMD));
        w_push         = bus.key_valid && w_key_ready;
        w_flush        = (r_state == S_ERROR) || (bus.status == ST_ERR);
        bus.key_ready  = w_key_ready;
        bus.cmd        = r_cmd;
        bus.fifo_level = w_level;
        bus.issuing    = (r_state == S_ISSUE) || (r_state == S_WAIT_DONE);
        bus.err        = r_err;
        bus.timeout    = r_timeout;
    end

`ifdef CALC_DISP_CAPTURE_EN
    logic [31:0] r_disp;
    logic        r_pos_was7;
    logic        r_disp_valid;

    // A frame is complete when position 7 is followed directly by a wrap to 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_disp       <= '0;
            r_pos_was7   <= 1'b0;
            r_disp_valid <= 1'b0;
        end else begin
            if (bus.pos <= 4'd7) r_disp[{bus.pos[2:0], 2'b00} +: 4] <= bus.data;
            r_pos_was7   <= (bus.pos == 4'd7);
            r_disp_valid <= r_pos_was7 && (bus.pos == 4'd0);
        end
    end

    assign bus.disp_digits = r_disp;
    assign bus.disp_valid  = r_disp_valid;
`else
`endif
endmodule

// File: tb/tb_calc_cmd_issuer.sv
// Scoreboard bench for calc_cmd_issuer: directed keys, a reactive calc model and a cmd monitor.
module tb_calc_cmd_issuer;
    import calc_pkg::*;

    localparam int         DEPTH   = 4;
    localparam int         TIMEOUT = 16;
    localparam logic [3:0] NOP     = 4'b1101;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    calc_cmd_issuer_if #(.DEPTH(DEPTH)) bus_if ();

    calc_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .NOP_CMD(NOP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] exp_q[$];
    int         peak_level = 0;

    logic       auto_mode;
    logic [1:0] man_st;
    logic [1:0] m_st;
    assign bus_if.status = auto_mode ? m_st : man_st;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_key(input logic [3:0] code, output logic rdy);
        bus_if.key_valid = 1'b1;
        bus_if.key_code  = code;
        #1;
        rdy = bus_if.key_ready;
        @(posedge clock);
        #1;
        bus_if.key_valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int n = 0;
        while ((bus_if.issuing || bus_if.fifo_level != 0) && n < maxc) begin
            tick();
            n++;
        end
        checks++;
        if (n >= maxc) begin
            failures++;
            $display("FAIL %s still busy after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic wait_cmd(input logic [3:0] code, input int maxc, input string name);
        int n = 0;
        while (bus_if.cmd !== code && n < maxc) begin
            tick();
            n++;
        end
        checks++;
        if (n >= maxc) begin
            failures++;
            $display("FAIL %s cmd=%0h required %0h within %0d cycles", name, bus_if.cmd, code, maxc);
        end
    endtask

    // Calc model: goes busy one cycle after a new cmd, stays busy 3 cycles, then ready.
    initial begin
        int   m_busy;
        logic m_pending;
        m_st = ST_READY;
        m_busy = 0;
        m_pending = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (!auto_mode) begin
                m_st = ST_READY;
                m_busy = 0;
                m_pending = 1'b0;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_st = ST_READY;
            end else if (m_pending) begin
                m_st = ST_BUSY;
                m_busy = 3;
                m_pending = 1'b0;
            end else if (bus_if.cmd !== NOP && m_st == ST_READY) begin
                m_pending = 1'b1;
            end
        end
    end

    // Monitor: every NOP->code transition on cmd is one issued command.
    initial begin
        logic [3:0] prev;
        prev = NOP;
        forever begin
            @(negedge clock);
            if (bus_if.cmd !== NOP && prev === NOP) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_cmd actual=%0h expected none", bus_if.cmd);
                end else begin
                    chk("cmd_order", bus_if.cmd, exp_q.pop_front());
                end
            end
            prev = bus_if.cmd;
            if (int'(bus_if.fifo_level) > peak_level) peak_level = int'(bus_if.fifo_level);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rdy;
        reset            = 1'b1;
        auto_mode        = 1'b0;
        man_st           = ST_READY;
        bus_if.key_valid = 1'b0;
        bus_if.key_code  = 4'd0;
`ifdef CALC_DISP_CAPTURE_EN
        bus_if.pos  = 4'd0;
        bus_if.data = 4'd0;
`endif
        repeat (2) tick();
        chk("rst_cmd", bus_if.cmd, NOP);
        chk("rst_level", bus_if.fifo_level, 0);
        chk("rst_key_ready", bus_if.key_ready, 1);
        chk("rst_issuing", bus_if.issuing, 0);
        chk("rst_err", bus_if.err, 0);
        chk("rst_timeout", bus_if.timeout, 0);
`ifdef CALC_DISP_CAPTURE_EN
        chk("rst_disp_digits", bus_if.disp_digits, 32'h0);
        chk("rst_disp_valid", bus_if.disp_valid, 0);
`endif
        reset = 1'b0;
        tick();

        // NOP code is never accepted
        bus_if.key_valid = 1'b1;
        bus_if.key_code  = NOP;
        #1;
        chk("nop_key_ready", bus_if.key_ready, 0);
        tick();
        bus_if.key_valid = 1'b0;
        chk("nop_level", bus_if.fifo_level, 0);

        // Test 1: back-to-back keys with a responsive calc
        auto_mode = 1'b1;
        exp_q.push_back(4'd3);
        exp_q.push_back(CMD_ADD);
        exp_q.push_back(4'd4);
        exp_q.push_back(CMD_EQ);
        push_key(4'd3, rdy);    chk("t1_rdy0", rdy, 1);
        push_key(CMD_ADD, rdy); chk("t1_rdy1", rdy, 1);
        push_key(4'd4, rdy);    chk("t1_rdy2", rdy, 1);
        push_key(CMD_EQ, rdy);  chk("t1_rdy3", rdy, 1);
        wait_idle(200, "t1_drain");
        repeat (3) tick();
        chk("t1_peak_level", peak_level, 3);
        chk("t1_level", bus_if.fifo_level, 0);
        chk("t1_sb_empty", exp_q.size(), 0);

        // Test 2: FIFO fills while calc busy
        auto_mode = 1'b0;
        man_st    = ST_BUSY;
        tick();
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd4);
        for (int i = 1; i <= 4; i++) begin
            push_key(4'(i), rdy);
            chk("t2_rdy", rdy, 1);
        end
        chk("t2_level_full", bus_if.fifo_level, 4);
        chk("t2_ready_full", bus_if.key_ready, 0);
        push_key(4'd5, rdy);
        chk("t2_fifth_rdy", rdy, 0);
        chk("t2_level_after5", bus_if.fifo_level, 4);
        auto_mode = 1'b1;
        wait_idle(200, "t2_drain");
        repeat (3) tick();
        chk("t2_sb_empty", exp_q.size(), 0);

        // Test 3: calc stuck ready -> timeout drop
        auto_mode = 1'b0;
        man_st    = ST_READY;
        exp_q.push_back(4'd7);
        push_key(4'd7, rdy);
        chk("t3_rdy", rdy, 1);
        wait_cmd(4'd7, 20, "t3_cmd7");
        begin
            int n = 0;
            while (!bus_if.timeout && n < 40) begin
                tick();
                n++;
            end
            chk("t3_timeout_cycles", n, TIMEOUT);
        end
        chk("t3_cmd_nop", bus_if.cmd, NOP);
        chk("t3_issuing", bus_if.issuing, 0);
        tick();
        chk("t3_timeout_pulse", bus_if.timeout, 0);
        auto_mode = 1'b1;
        exp_q.push_back(4'd5);
        push_key(4'd5, rdy);
        wait_idle(100, "t3_next_key");
        repeat (3) tick();
        chk("t3_sb_empty", exp_q.size(), 0);

        // Test 4: error during WAIT_DONE
        exp_q.push_back(4'd2);
        push_key(4'd2, rdy);
        push_key(4'd6, rdy);
        push_key(4'd8, rdy);
        begin
            int n = 0;
            while (!(bus_if.issuing && bus_if.cmd === NOP) && n < 30) begin
                tick();
                n++;
            end
            chk("t4_reach_wait_done", (n < 30), 1);
        end
        chk("t4_level_pending", bus_if.fifo_level, 2);
        auto_mode = 1'b0;
        man_st    = ST_ERR;
        tick();
        chk("t4_err", bus_if.err, 1);
        chk("t4_flush", bus_if.fifo_level, 0);
        chk("t4_key_ready", bus_if.key_ready, 0);
        chk("t4_cmd", bus_if.cmd, NOP);
        chk("t4_issuing", bus_if.issuing, 0);
        man_st = ST_READY;
        push_key(4'd1, rdy);
        chk("t4_push_rdy", rdy, 0);
        repeat (5) tick();
        chk("t4_err_sticky", bus_if.err, 1);
        chk("t4_level_stay", bus_if.fifo_level, 0);

        // Test 5: reset while ISSUE holds cmd 9
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_err_cleared", bus_if.err, 0);
        exp_q.push_back(4'd9);
        push_key(4'd9, rdy);
        push_key(4'd4, rdy);
        wait_cmd(4'd9, 20, "t5_cmd9");
        repeat (2) tick();
        chk("t5_cmd_held", bus_if.cmd, 4'd9);
        reset = 1'b1;
        tick();
        chk("t5_cmd", bus_if.cmd, NOP);
        chk("t5_level", bus_if.fifo_level, 0);
        chk("t5_err", bus_if.err, 0);
        chk("t5_issuing", bus_if.issuing, 0);
        reset = 1'b0;
        repeat (5) tick();
        chk("t5_level_after", bus_if.fifo_level, 0);
        chk("t5_cmd_after", bus_if.cmd, NOP);

`ifdef CALC_DISP_CAPTURE_EN
        // Test 6: display frame capture
        for (int i = 0; i < 8; i++) begin
            bus_if.pos  = 4'(i);
            bus_if.data = 4'(i + 1);
            tick();
            chk("t6_no_pulse", bus_if.disp_valid, 0);
        end
        bus_if.pos  = 4'd0;
        bus_if.data = 4'd1;
        tick();
        chk("t6_pulse", bus_if.disp_valid, 1);
        chk("t6_digits", bus_if.disp_digits, 32'h87654321);
        bus_if.pos  = 4'd8;
        bus_if.data = 4'hF;
        tick();
        chk("t6_pulse_end", bus_if.disp_valid, 0);
        chk("t6_digits_hold", bus_if.disp_digits, 32'h87654321);
`endif

        repeat (3) tick();
        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
